// File: rtl/regfile_sb.sv
// Multi-port register file with optional write-to-read forwarding, optional hardwired
// zero register and a one-bit-per-register pending-write scoreboard for RAW hazard detection.
module regfile_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        A1,
    input  logic [ADDR_W-1:0]        A2,
    output logic [DATA_W-1:0]        RD1,
    output logic [DATA_W-1:0]        RD2,
    output logic                     BUSY1,
    output logic                     BUSY2,
    input  logic [ADDR_W-1:0]        A3,
    input  logic [DATA_W-1:0]        WD3,
    input  logic                     WE3,
    input  logic [ADDR_W-1:0]        IA,
    input  logic                     IE,
    output logic [(1<<ADDR_W)-1:0]   PEND
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] data_vec [NREG];
    logic [NREG-1:0]   pend_vec;

    // One storage slot per register; the async clear rules out RAM inference.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        if (ZERO_REG != 0 && gi == 0) begin : g_zero
            assign data_vec[gi] = '0;
            assign pend_vec[gi] = 1'b0;
        end else begin : g_live
            logic [DATA_W-1:0] val_reg;
            logic              pend_reg;
            logic              wr_hit;
            logic              iss_hit;

            assign wr_hit  = WE3 && (A3 == ADDR_W'(gi));
            assign iss_hit = IE  && (IA == ADDR_W'(gi));

            // An issue on the same edge as a writeback wins: the new producer
            // supersedes the one being retired.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    val_reg  <= '0;
                    pend_reg <= 1'b0;
                end else begin
                    if (wr_hit) begin
                        val_reg <= WD3;
                    end
                    if (iss_hit) begin
                        pend_reg <= 1'b1;
                    end else if (wr_hit) begin
                        pend_reg <= 1'b0;
                    end
                end
            end

            assign data_vec[gi] = val_reg;
            assign pend_vec[gi] = pend_reg;
        end
    end

    assign PEND = pend_vec;

    logic [ADDR_W-1:0] addr_p [2];
    logic [DATA_W-1:0] rd_p   [2];
    logic              busy_p [2];

    assign addr_p[0] = A1;
    assign addr_p[1] = A2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_W-1:0] rd_val;
        logic              busy_val;

        always_comb begin
            rd_val   = '0;
            busy_val = 1'b0;
            if (!rst) begin
                if (ZERO_REG != 0 && addr_p[gi] == '0) begin
                    rd_val   = '0;
                    busy_val = 1'b0;
                end else if (BYPASS != 0 && WE3 && A3 == addr_p[gi]) begin
                    rd_val   = WD3;
                    busy_val = 1'b0;
                end else begin
                    rd_val   = data_vec[addr_p[gi]];
                    busy_val = pend_vec[addr_p[gi]];
                end
            end
        end

        assign rd_p[gi]   = rd_val;
        assign busy_p[gi] = busy_val;
    end

    assign RD1   = rd_p[0];
    assign RD2   = rd_p[1];
    assign BUSY1 = busy_p[0];
    assign BUSY2 = busy_p[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Checks three regfile_sb configurations (no bypass; bypass; bypass + zero register)
// driven by identical stimulus against an array-based reference model.
module tb_regfile_sb;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] A1, A2, A3, IA;
    logic [7:0] WD3;
    logic       WE3, IE;

    logic [7:0] rd1   [3];
    logic [7:0] rd2   [3];
    logic       busy1 [3];
    logic       busy2 [3];
    logic [7:0] pend  [3];

    int checks = 0;
    int errors = 0;

    // Reference state: config 0 = no bypass, 1 = bypass, 2 = bypass + zero register
    logic [7:0] mem [3][8];
    logic       pnd [3][8];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        logic [7:0] r1, r2, pv;
        logic       b1, b2;
        regfile_sb #(
            .DATA_W  (8),
            .ADDR_W  (3),
            .BYPASS  ((gi == 0) ? 0 : 1),
            .ZERO_REG((gi == 2) ? 1 : 0)
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .A1   (A1),
            .A2   (A2),
            .RD1  (r1),
            .RD2  (r2),
            .BUSY1(b1),
            .BUSY2(b2),
            .A3   (A3),
            .WD3  (WD3),
            .WE3  (WE3),
            .IA   (IA),
            .IE   (IE),
            .PEND (pv)
        );
        assign rd1[gi]   = r1;
        assign rd2[gi]   = r2;
        assign busy1[gi] = b1;
        assign busy2[gi] = b2;
        assign pend[gi]  = pv;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 8; i++) begin
                mem[c][i] = 8'h00;
                pnd[c][i] = 1'b0;
            end
    endtask

    task automatic exp_port(input int c, input logic [2:0] a, output logic [7:0] d, output logic b);
        bit byp = (c != 0);
        bit zr  = (c == 2);
        d = 8'h00;
        b = 1'b0;
        if (rst) begin
            d = 8'h00;
        end else if (zr && a == 3'd0) begin
            d = 8'h00;
        end else if (byp && WE3 && A3 == a) begin
            d = WD3;
        end else begin
            d = mem[c][a];
            b = pnd[c][a];
        end
    endtask

    task automatic update_model();
        if (!rst) begin
            for (int c = 0; c < 3; c++) begin
                bit zr = (c == 2);
                if (WE3 && !(zr && A3 == 3'd0)) begin
                    mem[c][A3] = WD3;
                    pnd[c][A3] = 1'b0;
                end
                if (IE && !(zr && IA == 3'd0))
                    pnd[c][IA] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] e1, e2, pv;
        logic       b1, b2;
        for (int c = 0; c < 3; c++) begin
            exp_port(c, A1, e1, b1);
            exp_port(c, A2, e2, b2);
            for (int i = 0; i < 8; i++) pv[i] = pnd[c][i];
            chk($sformatf("%s.c%0d.RD1", tag, c), rd1[c], e1);
            chk($sformatf("%s.c%0d.RD2", tag, c), rd2[c], e2);
            chk($sformatf("%s.c%0d.BUSY1", tag, c), {7'd0, busy1[c]}, {7'd0, b1});
            chk($sformatf("%s.c%0d.BUSY2", tag, c), {7'd0, busy2[c]}, {7'd0, b2});
            chk($sformatf("%s.c%0d.PEND", tag, c), pend[c], pv);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] a3, input logic [7:0] wd,
                         input logic ie, input logic [2:0] ia,
                         input logic [2:0] a1, input logic [2:0] a2);
        WE3 = we; A3 = a3; WD3 = wd; IE = ie; IA = ia; A1 = a1; A2 = a2;
    endtask

    // settle: check combinational outputs mid-cycle; edge: advance through a rising edge
    task automatic settle(input string tag);
        #2;
        check_all(tag);
        $display("step %-10s t=%0t A1=%0d A2=%0d WE3=%0b A3=%0d WD3=%h IE=%0b IA=%0d rst=%0b",
                 tag, $time, A1, A2, WE3, A3, WD3, IE, IA, rst);
    endtask

    task automatic edge_step();
        @(posedge clk);
        update_model();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
        clear_model();
        #12;
        check_all("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic write then read
        drive(1'b1, 3'd5, 8'h5A, 1'b0, 3'd0, 3'd5, 3'd0);
        settle("wr5");
        chk("wr5.nobyp.RD1", rd1[0], 8'h00);
        chk("wr5.byp.RD1", rd1[1], 8'h5A);
        edge_step();
        drive(1'b1, 3'd7, 8'hC3, 1'b0, 3'd0, 3'd5, 3'd7);
        settle("wr7");
        chk("rd5.nobyp.RD1", rd1[0], 8'h5A);
        edge_step();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd7);
        settle("rd7");
        chk("rd7.nobyp.RD2", rd2[0], 8'hC3);
        edge_step();

        // Bypass against a pending register
        drive(1'b1, 3'd3, 8'h11, 1'b1, 3'd3, 3'd3, 3'd3);
        settle("set3");
        edge_step();
        drive(1'b1, 3'd3, 8'h99, 1'b0, 3'd0, 3'd3, 3'd3);
        settle("byp3");
        chk("byp3.RD1", rd1[1], 8'h99);
        chk("byp3.RD2", rd2[1], 8'h99);
        chk("byp3.BUSY1", {7'd0, busy1[1]}, 8'h00);
        chk("byp3.nobyp.BUSY1", {7'd0, busy1[0]}, 8'h01);
        chk("byp3.nobyp.RD1", rd1[0], 8'h11);
        edge_step();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd3);
        settle("post3");
        chk("post3.PEND3", {7'd0, pend[1][3]}, 8'h00);
        edge_step();

        // Scoreboard: issue, hold busy, retire
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd2, 3'd0);
        settle("iss2");
        chk("iss2.BUSY1.pre", {7'd0, busy1[0]}, 8'h00);
        edge_step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd0);
            settle("idle2");
            chk("idle2.BUSY1", {7'd0, busy1[0]}, 8'h01);
            edge_step();
        end
        drive(1'b1, 3'd2, 8'h2A, 1'b0, 3'd0, 3'd2, 3'd0);
        settle("wb2");
        chk("wb2.byp.BUSY1", {7'd0, busy1[1]}, 8'h00);
        chk("wb2.byp.RD1", rd1[1], 8'h2A);
        chk("wb2.nobyp.BUSY1", {7'd0, busy1[0]}, 8'h01);
        edge_step();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd0);
        settle("rd2");
        chk("rd2.nobyp.RD1", rd1[0], 8'h2A);
        chk("rd2.nobyp.BUSY1", {7'd0, busy1[0]}, 8'h00);
        edge_step();

        // Simultaneous issue and writeback on r4
        drive(1'b1, 3'd4, 8'h44, 1'b1, 3'd4, 3'd1, 3'd0);
        settle("both4");
        edge_step();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd0);
        settle("rd4");
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rd4.c%0d.RD1", c), rd1[c], 8'h44);
            chk($sformatf("rd4.c%0d.PEND4", c), {7'd0, pend[c][4]}, 8'h01);
        end
        edge_step();

        // Zero register
        drive(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd0, 3'd0);
        settle("wr0");
        chk("wr0.zr.RD1", rd1[2], 8'h00);
        edge_step();
        drive(1'b1, 3'd1, 8'h77, 1'b0, 3'd0, 3'd0, 3'd1);
        settle("rd0");
        chk("rd0.zr.RD1", rd1[2], 8'h00);
        chk("rd0.zr.BUSY1", {7'd0, busy1[2]}, 8'h00);
        chk("rd0.zr.PEND0", {7'd0, pend[2][0]}, 8'h00);
        chk("rd0.plain.RD1", rd1[0], 8'hFF);
        chk("rd0.plain.PEND0", {7'd0, pend[0][0]}, 8'h01);
        edge_step();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd1, 3'd0);
        settle("rd1");
        chk("rd1.zr.RD1", rd1[2], 8'h77);
        edge_step();

        // Asynchronous reset mid-cycle, with a write held during reset
        drive(1'b1, 3'd6, 8'hE6, 1'b1, 3'd5, 3'd5, 3'd4);
        settle("prerst");
        rst = 1'b1;
        clear_model();
        #1;
        check_all("rstmid");
        for (int c = 0; c < 3; c++)
            chk($sformatf("rstmid.c%0d.PEND", c), pend[c], 8'h00);
        edge_step();
        settle("rsthold");
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
        rst = 1'b0;
        edge_step();
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'(a), 3'(7 - a));
            settle("postrst");
            chk("postrst.RD1", rd1[1], 8'h00);
            chk("postrst.BUSY1", {7'd0, busy1[0]}, 8'h00);
            edge_step();
        end

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            rst = 1'b0;
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                clear_model();
            end
            settle("rand");
            edge_step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
